// File: rtl/uram_sdp_reader.sv
// uram_sdp_reader: burst read sequencer for the simple-dual-port UltraRAM buffer.
// A read is issued only while the skid FIFO has a free slot for every word
// that could still be in flight. Each issued read is tagged through a
// latency-matched shift register, and the returned words are presented on a
// registered valid/ready stream. The stream output register counts as one
// FIFO entry.
module uram_sdp_reader #(
    parameter int ADDR_WIDTH   = 21,
    parameter int DATA_WIDTH   = 72,
    parameter int LEN_WIDTH    = 16,
    parameter int READ_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_enb,
    output logic                  mem_regceb,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    logic [1:0]              state_r;
    logic [1:0]              state_next_s;
    logic                    done_next_s;
    logic [LEN_WIDTH-1:0]    remaining_r;

    logic [READ_LATENCY-1:0] tag_issue_r;
    logic [READ_LATENCY-1:0] tag_last_r;

    logic [DATA_WIDTH:0]     buf_mem_r [FIFO_DEPTH];
    logic [PW-1:0]           buf_wr_ptr_r;
    logic [PW-1:0]           buf_rd_ptr_r;
    logic [PW:0]             buf_count_r;

    logic [CW-1:0]           inflight_s;
    logic [CW-1:0]           occupancy_s;
    logic                    credit_ok_s;
    logic                    issue_s;
    logic                    final_issue_s;
    logic                    accept_s;
    logic                    push_s;
    logic                    push_last_s;
    logic                    pop_s;
    logic                    out_free_s;
    logic                    buf_empty_s;
    logic                    buf_push_s;
    logic                    buf_pop_s;
    logic                    last_pop_s;

    // Count reads issued but not yet landed in the FIFO (tags still in the pipe).
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + CW'(tag_issue_r[i]);
        end
    end

    // Words held by the FIFO: buffered entries plus the stream output register.
    assign occupancy_s   = CW'(buf_count_r) + CW'(m_valid);
    // The pop happening this cycle is not credited, which keeps the rule
    // free of any path from m_ready.
    assign credit_ok_s   = (inflight_s + occupancy_s) < CW'(FIFO_DEPTH);
    assign issue_s       = (state_r == ST_ISSUE) && credit_ok_s;
    assign final_issue_s = issue_s && (remaining_r == LEN_WIDTH'(1));
    assign accept_s      = (state_r == ST_IDLE) && start && (length != '0);

    assign push_s        = tag_issue_r[READ_LATENCY-1];
    assign push_last_s   = tag_last_r[READ_LATENCY-1];
    assign pop_s         = m_valid && m_ready;
    assign out_free_s    = !m_valid || pop_s;
    assign buf_empty_s   = (buf_count_r == '0);
    // A word bypasses the buffer only when the output register is free and
    // nothing older is waiting in the buffer.
    assign buf_push_s    = push_s && !(out_free_s && buf_empty_s);
    assign buf_pop_s     = out_free_s && !buf_empty_s;
    assign last_pop_s    = pop_s && m_last;

    // Next-state and done-pulse decode for the IDLE/ISSUE/DRAIN sequencer.
    always_comb begin
        state_next_s = state_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (final_issue_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_next_s = ST_IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, memory port controls, address and remaining-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            mem_addrb   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_enb     <= 1'b0;
            mem_regceb  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            busy       <= (state_next_s != ST_IDLE);
            mem_enb    <= (state_next_s != ST_IDLE);
            mem_regceb <= (state_next_s != ST_IDLE);
            done       <= done_next_s;
            if (accept_s) begin
                mem_addrb   <= start_addr;
                remaining_r <= length;
            end else if (issue_s) begin
                // Natural binary overflow provides the wrap to address 0.
                mem_addrb   <= mem_addrb + ADDR_WIDTH'(1);
                remaining_r <= remaining_r - LEN_WIDTH'(1);
            end else begin
                mem_addrb   <= mem_addrb;
                remaining_r <= remaining_r;
            end
        end
    end

    // Tag shift register running alongside the memory read pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_issue_r <= '0;
            tag_last_r  <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                tag_issue_r[i] <= tag_issue_r[i-1];
                tag_last_r[i]  <= tag_last_r[i-1];
            end
            tag_issue_r[0] <= issue_s;
            tag_last_r[0]  <= final_issue_s;
        end
    end

    // Skid buffer storage; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (buf_push_s) begin
            buf_mem_r[buf_wr_ptr_r] <= {push_last_s, mem_doutb};
        end
    end

    // Skid buffer pointers/count and the registered stream output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr_ptr_r <= '0;
            buf_rd_ptr_r <= '0;
            buf_count_r  <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
        end else begin
            if (buf_push_s) begin
                buf_wr_ptr_r <= buf_wr_ptr_r + PW'(1);
            end
            if (buf_pop_s) begin
                buf_rd_ptr_r <= buf_rd_ptr_r + PW'(1);
            end
            case ({buf_push_s, buf_pop_s})
                2'b10:   buf_count_r <= buf_count_r + (PW+1)'(1);
                2'b01:   buf_count_r <= buf_count_r - (PW+1)'(1);
                default: buf_count_r <= buf_count_r;
            endcase
            if (out_free_s) begin
                if (!buf_empty_s) begin
                    m_valid          <= 1'b1;
                    {m_last, m_data} <= buf_mem_r[buf_rd_ptr_r];
                end else if (push_s) begin
                    m_valid <= 1'b1;
                    m_data  <= mem_doutb;
                    m_last  <= push_last_s;
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/uram_sdp_reader.md
# uram_sdp_reader

Read-side sequencer for the simple-dual-port UltraRAM buffer. It accepts a burst command (start address, word count) and drives the memory read port: enable, output-register enable and address. It tracks the fixed read latency of the memory and delivers the returned words on a valid/ready stream. A credit-checked skid FIFO absorbs in-flight words under backpressure, so no read data is ever dropped. It sits between the URAM read port and downstream stream consumers, on the same clock as the memory read port.

## Interface
Parameters:
- ADDR_WIDTH, 21, memory word-address width.
- DATA_WIDTH, 72, memory/stream word width.
- LEN_WIDTH, 16, burst length width (words).
- READ_LATENCY, 4, cycles from an enb-high cycle to valid mem_doutb; legal range 1..8.
- FIFO_DEPTH, 8, skid FIFO entries; power of two, at least READ_LATENCY+2.

Ports:
- clk  in  1  single clock; the memory read clock is driven from this same net.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address.
- length  in  LEN_WIDTH  number of words to read.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst completion.
- mem_enb  out  1  memory port-B enable.
- mem_regceb  out  1  memory port-B output-register enable.
- mem_addrb  out  ADDR_WIDTH  memory port-B address.
- mem_doutb  in  DATA_WIDTH  memory port-B read data.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of a burst; qualified by m_valid.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with length≠0: latch start_addr and length, go to ISSUE.
  - start with length=0: pulse done on the next cycle, stay IDLE, busy stays low.
  - start is ignored outside IDLE.
- mem_enb and mem_regceb:
  - Both held high throughout ISSUE and DRAIN; low in IDLE.
  - This keeps the memory pipeline advancing every cycle.
- Issue rule in ISSUE:
  - A read is issued on a cycle where inflight + fifo_count < FIFO_DEPTH.
  - inflight counts issued reads whose data has not yet reached the FIFO.
  - When a read is issued, mem_addrb advances by 1 on the next cycle, and the remaining count decrements.
  - On a non-issue cycle, mem_addrb holds. The re-read word is discarded.
- Address wrap: after 2^ADDR_WIDTH−1, mem_addrb wraps to 0.
- Tag pipeline:
  - A READ_LATENCY-deep shift register carries an "issued" bit and a "last" bit alongside the memory.
  - When the tag emerges, mem_doutb and the last bit are pushed into the FIFO.
  - Untagged words are discarded.
- ISSUE → DRAIN on the cycle the final read is issued.
- DRAIN → IDLE on the m_valid&m_ready handshake of the m_last word. done pulses on that same transition.
- The credit rule guarantees the FIFO never overflows. An overflow condition is a design error, and the bench asserts on it.
- Reset, including mid-burst:
  - State goes to IDLE; counters, tags and FIFO are cleared.
  - All in-flight data is discarded.
  - Memory output arriving after reset is ignored.

## Timing
- Reset values: busy=0, done=0, mem_enb=0, mem_regceb=0, mem_addrb=0, m_valid=0, m_last=0, m_data=0.
- Start accepted at cycle 0:
  - Cycle 1: busy=1, mem_enb=1, mem_addrb=start_addr (first issue).
  - Cycle 1+READ_LATENCY: word at FIFO input.
  - Cycle 2+READ_LATENCY: first m_valid (registered FIFO output).
- With m_ready held high and FIFO_DEPTH ≥ READ_LATENCY+2: one word per cycle, no issue bubbles.
  - Default parameters, length=N: first m_valid at cycle 6, last at cycle N+5, done at cycle N+6.
- done and the busy falling edge occur in the same cycle. A new start is accepted in that cycle's IDLE, one cycle after the last handshake.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- The m_valid, m_data and m_last outputs are registered; there is no combinational path from m_ready to any output.

## Test plan
- Basic burst: start_addr=0x10, length=4, m_ready=1, memory word = address → m_data 0x10..0x13 on cycles 6..9, m_last on 0x13, done at cycle 10.
- Backpressure: length=32, m_ready toggled randomly (~50%) → all 32 words delivered in order with none lost or duplicated; FIFO never overflows; issue stalls when the credit limit is reached.
- Wrap: start_addr=0x1FFFFE, length=4 → addresses 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001 delivered in that order.
- Zero and single length:
  - length=0 → done pulse at cycle 1, no m_valid, mem_enb stays 0.
  - length=1 → one word with m_last=1.
- Start while busy: second start pulsed during a length=8 burst → ignored; exactly 8 words delivered, one done pulse.
- Reset mid-burst: rst asserted during DRAIN of a length=16 burst with m_ready=0 → all outputs at reset values immediately; no stale m_valid after release; a following burst with length=2 returns correct data.
